// File: rtl/move_controller.sv
// Connect Four move controller: turns raw keycodes into one-shot cursor moves and
// acknowledged single-cycle piece drops, alternating colours between players.
module move_controller #(
  parameter int         NUM_COLS    = 7,
  parameter int         NUM_ROWS    = 6,
  parameter logic [7:0] KEY_LEFT    = 8'h50,
  parameter logic [7:0] KEY_RIGHT   = 8'h4F,
  parameter logic [7:0] KEY_DROP    = 8'h2C,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          keycode,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_over,
  input  logic                drop_done,
  output logic                drop_valid,
  output logic [2:0]          drop_col,
  output logic                drop_red,
  output logic [2:0]          cursor_col,
  output logic                turn_red,
  output logic [5:0]          move_count,
  output logic                invalid_move,
  output logic                locked
);

  localparam logic [5:0] BOARD_CELLS = 6'(NUM_COLS * NUM_ROWS);
  localparam logic [2:0] LAST_COL    = 3'(NUM_COLS - 1);
  localparam logic [2:0] HOME_COL    = 3'(NUM_COLS / 2);
  localparam logic [7:0] TIMER_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, LOCKED} state_t;

  state_t     state_reg, state_next;
  logic [7:0] prev_key_reg;
  logic [2:0] cursor_reg, cursor_next;
  logic [2:0] drop_col_reg, drop_col_next;
  logic       drop_red_reg, drop_red_next;
  logic       turn_red_reg, turn_red_next;
  logic [5:0] move_count_reg, move_count_next;
  logic       invalid_reg, invalid_next;
  logic [7:0] timer_reg, timer_next;
  logic       key_new, key_left, key_right, key_drop, take_ack;

  // Only a change of keycode counts, so a held key fires once.
  assign key_new   = (keycode != prev_key_reg);
  assign key_left  = key_new && (keycode == KEY_LEFT);
  assign key_right = key_new && (keycode == KEY_RIGHT);
  assign key_drop  = key_new && (keycode == KEY_DROP);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      prev_key_reg   <= 8'h00;
      cursor_reg     <= HOME_COL;
      drop_col_reg   <= 3'd0;
      drop_red_reg   <= 1'b0;
      turn_red_reg   <= 1'b1;
      move_count_reg <= 6'd0;
      invalid_reg    <= 1'b0;
      timer_reg      <= 8'd0;
    end else begin
      state_reg      <= state_next;
      prev_key_reg   <= keycode;
      cursor_reg     <= cursor_next;
      drop_col_reg   <= drop_col_next;
      drop_red_reg   <= drop_red_next;
      turn_red_reg   <= turn_red_next;
      move_count_reg <= move_count_next;
      invalid_reg    <= invalid_next;
      timer_reg      <= timer_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cursor_next     = cursor_reg;
    drop_col_next   = drop_col_reg;
    drop_red_next   = drop_red_reg;
    turn_red_next   = turn_red_reg;
    move_count_next = move_count_reg;
    invalid_next    = 1'b0;
    timer_next      = timer_reg;
    take_ack        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (game_over) begin
          state_next = LOCKED;
        end else if (key_left) begin
          cursor_next = (cursor_reg == 3'd0) ? LAST_COL : cursor_reg - 3'd1;
        end else if (key_right) begin
          cursor_next = (cursor_reg == LAST_COL) ? 3'd0 : cursor_reg + 3'd1;
        end else if (key_drop) begin
          if (col_full[cursor_reg]) begin
            invalid_next = 1'b1;
          end else begin
            drop_col_next = cursor_reg;
            drop_red_next = turn_red_reg;
            state_next    = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_next = 8'd0;
        if (drop_done) take_ack = 1'b1;
        else           state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack arriving in the final timeout cycle still counts.
        if (drop_done) begin
          take_ack = 1'b1;
        end else if (timer_reg == TIMER_LAST) begin
          invalid_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      default: ;
    endcase

    if (take_ack) begin
      turn_red_next   = ~turn_red_reg;
      move_count_next = move_count_reg + 6'd1;
      state_next      = (game_over || (move_count_next == BOARD_CELLS)) ? LOCKED : IDLE;
    end
  end

  assign drop_valid   = (state_reg == ISSUE);
  assign locked       = (state_reg == LOCKED);
  assign drop_col     = drop_col_reg;
  assign drop_red     = drop_red_reg;
  assign cursor_col   = cursor_reg;
  assign turn_red     = turn_red_reg;
  assign move_count   = move_count_reg;
  assign invalid_move = invalid_reg;

endmodule
